// File: rtl/clock_switch_ctrl_if.sv
// Request/done handshake and mux/gate drive signals between a requester and clock_switch_ctrl.
interface clock_switch_ctrl_if;
    logic req_valid_i;
    logic req_sel_i;
    logic req_ready_o;
    logic done_o;
    logic clk_sel_o;
    logic clk_en_o;
    logic busy_o;

    modport master (
        output req_valid_i,
        output req_sel_i,
        input  req_ready_o,
        input  done_o,
        input  clk_sel_o,
        input  clk_en_o,
        input  busy_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        output req_ready_o,
        output done_o,
        output clk_sel_o,
        output clk_en_o,
        output busy_o
    );
endinterface

// File: rtl/clock_switch_ctrl.sv
// Glitch-safe clock mux select sequencer: gate, settle, switch, settle, ungate, report done.
module clock_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic        INIT_SEL      = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    clock_switch_ctrl_if.slave bus
);

    localparam int unsigned          CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel_tgt;
    logic             clk_sel;
    logic             clk_en;
    logic             done;
    logic             ready_c;
    logic             accept_c;

    // Ready is held low during reset so nothing is accepted on a reset edge.
    assign ready_c  = !rst_i && (state == IDLE);
    assign accept_c = bus.req_valid_i && ready_c;

    assign bus.req_ready_o = ready_c;
    assign bus.busy_o      = !ready_c;
    assign bus.clk_sel_o   = clk_sel;
    assign bus.clk_en_o    = clk_en;
    assign bus.done_o      = done;

    // Select only moves inside the gated window; reset restores the initial select outright.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_tgt <= INIT_SEL;
            clk_sel <= INIT_SEL;
            clk_en  <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (bus.req_sel_i != clk_sel) begin
                            state   <= GATE;
                            clk_en  <= 1'b0;
                            cnt     <= CNT_LOAD;
                            sel_tgt <= bus.req_sel_i;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        state   <= SWITCH;
                        clk_sel <= sel_tgt;
                        cnt     <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SWITCH: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        clk_en <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
